icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's IF port.
- Accepts fetch requests from IF and returns hits with one-cycle latency.
- Fills misses through the byte-serial memory controller using a 4-byte read.
- Removes repeated multi-cycle instruction fetches from the shared RAM port, so the MEM stage gets more memory bandwidth.

Parameters:
- IDX_W, 6, index width; number of lines = 2**IDX_W (64).
- ADDR_W, 18, significant physical address bits; tag = addr[ADDR_W-1:2+IDX_W].

Ports:
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  asynchronous reset, active-low (0 = reset)
- rdy_in  input  1  global ready; low freezes all state and holds outputs
- flush  input  1  taken-jump kill; cancels delivery of the in-flight fetch
- if_req  input  1  IF requests the instruction at if_addr
- if_addr  input  32  fetch address, word aligned (bits [1:0] ignored)
- if_rdy  output  1  one-cycle pulse: if_ins is valid for the accepted request
- if_ins  output  32  fetched instruction word
- mc_op  output  2  memory-controller op: 2'b00 idle, 2'b01 read
- mc_len  output  2  access length: 2'b11 = 4 bytes
- mc_addr  output  32  memory-controller byte address, {addr[31:2],2'b00}
- mc_rdy  input  1  memory controller done pulse; mc_out valid this cycle
- mc_out  input  32  little-endian word returned by the memory controller

Behaviour:
- Storage per line: valid bit, tag, 32-bit data.
- Reset (rst_in=0, asynchronous):
  - all valid bits cleared; state=IDLE
  - if_rdy=0, if_ins=0, mc_op=2'b00, mc_len=2'b00, mc_addr=0
  - the data and tag arrays need no reset
- rdy_in=0: no state, array, counter or output register changes; mc_op is held.
- States: IDLE, MISS, DONE.
- IDLE:
  - if_req=1 and flush=0 → latch if_addr as req_addr and look up the index.
  - Hit (valid and tag match, and req_addr[17:16]!=2'b11): next cycle if_rdy=1, if_ins=line data; stay IDLE.
  - Miss, or IO address: next cycle state=MISS, mc_op=01, mc_len=11, mc_addr=aligned req_addr.
  - if_req=1 together with flush=1 is ignored.
- Hit throughput: back-to-back hits are accepted every cycle; if_rdy may be high on consecutive cycles.
- MISS:
  - mc_op, mc_len and mc_addr are held stable until mc_rdy.
  - On mc_rdy:
    - write the line with valid=1, tag, data=mc_out (skipped for IO addresses)
    - mc_op=00, mc_len=00
    - if no kill is pending: if_rdy=1, if_ins=mc_out
    - state=DONE
- DONE: one bubble cycle (memory controller turnaround), if_rdy=0, then IDLE. Requests are not accepted in DONE.
- flush during MISS:
  - The outstanding controller read cannot be aborted; it completes and fills the line.
  - A kill flag is set; at mc_rdy, if_rdy stays 0. The kill flag clears on DONE.
- flush on the same cycle as mc_rdy: counts as a kill; no if_rdy.
- flush in IDLE: cancels any if_rdy that would be produced the next cycle.
- if_rdy is a single-cycle pulse; if_ins holds its last value when if_rdy=0.
- Latency: hit 1 cycle after acceptance; miss = 1 + controller latency (≥5 cycles for 4 bytes), plus the DONE bubble before the next accept.
- Index/tag wrap: addresses differing only in the tag evict each other; no associativity.
- rst_in asserted mid-miss:
  - all state is cleared
  - mc_op drops to 00 asynchronously
  - a late mc_rdy arriving in IDLE is ignored

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0]:
  - cleared by reset
  - incremented at accept time (hit or miss, IO counted as miss)
  - frozen while rdy_in=0
  - wrap at 2**32
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: reset, if_req addr=0x00000010, mc_rdy after 5 cycles with mc_out=0x00500093 → mc_op=01, mc_len=11, mc_addr=0x10 held; if_rdy=1, if_ins=0x00500093 on the mc_rdy cycle+1; DONE bubble.
- Hit: re-request 0x10 → if_rdy=1 one cycle later with 0x00500093, mc_op stays 00; then requests 0x10 and 0x10 back-to-back → two consecutive if_rdy pulses.
- Conflict eviction: fill 0x10, then 0x110 (same index, IDX_W=6) with 0x12345678, then request 0x10 → miss again, mc_addr=0x10.
- Flush mid-miss: request 0x20, assert flush 2 cycles later, mc_rdy with 0xDEADBEEF → no if_rdy; a later request to 0x20 hits with 0xDEADBEEF.
- rdy_in low: drop rdy_in for 3 cycles during MISS while mc_rdy=0 → mc_op/mc_addr unchanged, no state change; resumes correctly.
- Async reset mid-miss: rst_in=0 between clock edges → mc_op=00 immediately; after release, request 0x10 misses (valid cleared). With ICACHE_STATS_EN: hit_cnt/miss_cnt match the counted accesses of the prior tests.

Source files
------------

// File: rtl/icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : icache_direct                                              |
// | Description : Direct-mapped, one-word-per-line instruction cache between |
// |               the IF stage and the byte-serial memory controller port.   |
// |               Optional hit/miss counters under `ICACHE_STATS_EN.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module icache_direct #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rdy,
  output logic [31:0] if_ins,
  output logic [1:0]  mc_op,
  output logic [1:0]  mc_len,
  output logic [31:0] mc_addr,
  input  logic        mc_rdy,
  input  logic [31:0] mc_out
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int c_lines = 2 ** IDX_W;
  localparam int c_tag_w = ADDR_W - 2 - IDX_W;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_miss = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [1:0] c_op_idle  = 2'b00;
  localparam logic [1:0] c_op_read  = 2'b01;
  localparam logic [1:0] c_len_none = 2'b00;
  localparam logic [1:0] c_len_word = 2'b11;

  logic [1:0]          r_state;
  logic                r_kill;
  logic [ADDR_W-1:2]   r_req_addr;
  logic [c_lines-1:0]  r_valid;
  logic [c_tag_w-1:0]  r_tag_mem  [c_lines];
  logic [31:0]         r_data_mem [c_lines];

  logic [IDX_W-1:0]    w_idx;
  logic [c_tag_w-1:0]  w_tag;
  logic                w_io;
  logic                w_accept;
  logic                w_hit;
  logic [IDX_W-1:0]    w_fill_idx;
  logic [c_tag_w-1:0]  w_fill_tag;
  logic                w_fill_io;
  logic                w_fill;
  logic                w_unused;

  // Lookup happens on the incoming address so a hit can be returned next cycle.
  assign w_idx    = if_addr[2+IDX_W-1:2];
  assign w_tag    = if_addr[ADDR_W-1:2+IDX_W];
  assign w_io     = (if_addr[ADDR_W-1:ADDR_W-2] == 2'b11);
  assign w_accept = (r_state == c_idle) && if_req && !flush;
  assign w_hit    = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag) && !w_io;

  assign w_fill_idx = r_req_addr[2+IDX_W-1:2];
  assign w_fill_tag = r_req_addr[ADDR_W-1:2+IDX_W];
  assign w_fill_io  = (r_req_addr[ADDR_W-1:ADDR_W-2] == 2'b11);
  assign w_fill     = (r_state == c_miss) && mc_rdy && rdy_in;

  assign w_unused = ^if_addr[1:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= c_idle;
      r_kill     <= 1'b0;
      r_req_addr <= '0;
      r_valid    <= '0;
      if_rdy     <= 1'b0;
      if_ins     <= 32'd0;
      mc_op      <= c_op_idle;
      mc_len     <= c_len_none;
      mc_addr    <= 32'd0;
    end else if (rdy_in) begin
      if_rdy <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_req_addr <= if_addr[ADDR_W-1:2];
            if (w_hit) begin
              if_rdy <= 1'b1;
              if_ins <= r_data_mem[w_idx];
            end else begin
              r_state <= c_miss;
              mc_op   <= c_op_read;
              mc_len  <= c_len_word;
              mc_addr <= {if_addr[31:2], 2'b00};
            end
          end
        end
        c_miss: begin
          if (flush) begin
            r_kill <= 1'b1;
          end
          if (mc_rdy) begin
            // The read cannot be aborted: the line fills even when delivery is killed.
            if (!w_fill_io) begin
              r_valid[w_fill_idx] <= 1'b1;
            end
            mc_op  <= c_op_idle;
            mc_len <= c_len_none;
            if (!r_kill && !flush) begin
              if_rdy <= 1'b1;
              if_ins <= mc_out;
            end
            r_state <= c_done;
          end
        end
        c_done: begin
          r_kill  <= 1'b0;
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_fill && !w_fill_io) begin
      r_tag_mem[w_fill_idx]  <= w_fill_tag;
      r_data_mem[w_fill_idx] <= mc_out;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (rdy_in && w_accept) begin
      if (w_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_icache_direct                                           |
// | Description : Randomised self-checking bench for icache_direct against a |
// |               transaction-level direct-mapped cache model.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rdy;
  logic [31:0] if_ins;
  logic [1:0]  mc_op;
  logic [1:0]  mc_len;
  logic [31:0] mc_addr;
  logic        mc_rdy;
  logic [31:0] mc_out;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_direct #(.IDX_W(6), .ADDR_W(18)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .flush   (flush),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdy  (if_rdy),
    .if_ins  (if_ins),
    .mc_op   (mc_op),
    .mc_len  (mc_len),
    .mc_addr (mc_addr),
    .mc_rdy  (mc_rdy),
    .mc_out  (mc_out)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents of each cache line plus expected output registers.
  bit          m_valid [64];
  logic [9:0]  m_tag   [64];
  logic [31:0] m_data  [64];
  logic        exp_rdy;
  logic [31:0] exp_ins;
  int          n_hit;
  int          n_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    exp_rdy = 1'b0;
    exp_ins = 32'd0;
    n_hit   = 0;
    n_miss  = 0;
  endtask

  // Idle cycles: no request, or a request masked by flush; neither is accepted.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if_req  = $urandom_range(0, 1);
      flush   = if_req;
      if_addr = $urandom;
      @(posedge clk_in); #1;
      if_req = 1'b0; flush = 1'b0;
      exp_rdy = 1'b0;
      check("idle_rdy", {31'd0, if_rdy}, 32'd0);
      check("idle_op", {30'd0, mc_op}, 32'd0);
    end
  endtask

  // rdy_in low in IDLE: outputs hold, any request is lost.
  task automatic freeze(input int n);
    for (int i = 0; i < n; i++) begin
      rdy_in  = 1'b0;
      if_req  = $urandom_range(0, 1);
      flush   = $urandom_range(0, 1);
      if_addr = $urandom;
      @(posedge clk_in); #1;
      check("frz_rdy", {31'd0, if_rdy}, {31'd0, exp_rdy});
      check("frz_ins", if_ins, exp_ins);
      check("frz_op", {30'd0, mc_op}, 32'd0);
    end
    rdy_in = 1'b1; if_req = 1'b0; flush = 1'b0;
  endtask

  // One fetch transaction. lat = MISS cycles before mc_rdy; flush_at = MISS cycle
  // index carrying flush (lat means together with mc_rdy, -1 none); freeze_at =
  // MISS cycle before which rdy_in drops for 3 cycles (-1 none).
  task automatic fetch(input logic [31:0] addr, input int lat, input int flush_at,
                       input int freeze_at, input logic [31:0] data);
    int          idx;
    logic [9:0]  tg;
    logic        io;
    logic        hit;
    logic        killed;
    logic [31:0] maddr;
    idx   = int'(addr[7:2]);
    tg    = addr[17:8];
    io    = (addr[17:16] == 2'b11);
    hit   = m_valid[idx] && (m_tag[idx] == tg) && !io;
    maddr = {addr[31:2], 2'b00};
    if_req = 1'b1; if_addr = addr; flush = 1'b0;
    @(posedge clk_in); #1;
    if_req = 1'b0; if_addr = $urandom;
    if (hit) begin
      n_hit++;
      exp_rdy = 1'b1;
      exp_ins = m_data[idx];
      check("hit_rdy", {31'd0, if_rdy}, 32'd1);
      check("hit_ins", if_ins, exp_ins);
      check("hit_op", {30'd0, mc_op}, 32'd0);
    end else begin
      n_miss++;
      exp_rdy = 1'b0;
      killed  = 1'b0;
      check("miss_rdy", {31'd0, if_rdy}, 32'd0);
      check("miss_op", {30'd0, mc_op}, 32'd1);
      check("miss_len", {30'd0, mc_len}, 32'd3);
      check("miss_addr", mc_addr, maddr);
      for (int c = 0; c < lat; c++) begin
        if (c == freeze_at) begin
          for (int f = 0; f < 3; f++) begin
            rdy_in = 1'b0; mc_rdy = 1'b0;
            flush  = $urandom_range(0, 1);
            if_req = $urandom_range(0, 1);
            @(posedge clk_in); #1;
            check("mfrz_op", {30'd0, mc_op}, 32'd1);
            check("mfrz_addr", mc_addr, maddr);
            check("mfrz_rdy", {31'd0, if_rdy}, 32'd0);
          end
          rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0;
        end
        flush  = (c == flush_at);
        if (flush) killed = 1'b1;
        if_req = $urandom_range(0, 1);
        @(posedge clk_in); #1;
        flush = 1'b0; if_req = 1'b0;
        check("wait_op", {30'd0, mc_op}, 32'd1);
        check("wait_len", {30'd0, mc_len}, 32'd3);
        check("wait_addr", mc_addr, maddr);
        check("wait_rdy", {31'd0, if_rdy}, 32'd0);
      end
      flush  = (flush_at == lat);
      if (flush) killed = 1'b1;
      mc_rdy = 1'b1; mc_out = data;
      @(posedge clk_in); #1;
      mc_rdy = 1'b0; flush = 1'b0; mc_out = $urandom;
      if (!killed) begin
        exp_rdy = 1'b1;
        exp_ins = data;
      end
      check("fill_rdy", {31'd0, if_rdy}, {31'd0, exp_rdy});
      check("fill_ins", if_ins, exp_ins);
      check("fill_op", {30'd0, mc_op}, 32'd0);
      check("fill_len", {30'd0, mc_len}, 32'd0);
      if (!io) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = data;
      end
      // Bubble cycle: a request here must be ignored.
      if_req = 1'b1; if_addr = $urandom;
      @(posedge clk_in); #1;
      if_req = 1'b0;
      exp_rdy = 1'b0;
      check("done_rdy", {31'd0, if_rdy}, 32'd0);
      check("done_op", {30'd0, mc_op}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          lat;
    int          fa;
    int          za;
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0;
    if_addr = 32'd0; mc_rdy = 1'b0; mc_out = 32'd0;
    model_clear();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_rdy", {31'd0, if_rdy}, 32'd0);
    check("rst_ins", if_ins, 32'd0);
    check("rst_op", {30'd0, mc_op}, 32'd0);
    check("rst_len", {30'd0, mc_len}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    #2 rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Directed scenarios
    fetch(32'h10, 4, -1, -1, 32'h00500093);
    idle(1);
    fetch(32'h10, 0, -1, -1, 32'h0);
    fetch(32'h10, 0, -1, -1, 32'h0);
    fetch(32'h10, 0, -1, -1, 32'h0);
    freeze(2);
    fetch(32'h110, 5, -1, -1, 32'h12345678);
    fetch(32'h10, 5, -1, -1, 32'h00500093);
    fetch(32'h20, 5, 1, -1, 32'hDEADBEEF);
    fetch(32'h20, 0, -1, -1, 32'h0);
    fetch(32'h30, 5, -1, 2, 32'hCAFEF00D);
    fetch(32'h30, 0, -1, -1, 32'h0);
    fetch(32'h30040, 3, -1, -1, 32'h0BADF00D);
    fetch(32'h30040, 3, -1, -1, 32'h0BADF00E);
    fetch(32'h44, 3, 3, -1, 32'h55AA55AA);
    fetch(32'h44, 0, -1, -1, 32'h0);

    // Randomised traffic over a few indices and tags to force hits and evictions
    for (int it = 0; it < 200; it++) begin
      a = $urandom;
      a[7:2]   = 6'($urandom_range(0, 3));
      a[15:8]  = 8'($urandom_range(0, 2));
      a[17:16] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00;
      if ($urandom_range(0, 3) != 0) a[31:18] = 14'd0;
      lat = $urandom_range(1, 6);
      fa  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat)) : -1;
      za  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      fetch(a, lat, fa, za, $urandom);
      case ($urandom_range(0, 3))
        0: idle(1);
        1: freeze(2);
        default: ;
      endcase
    end

    // Make 0x10 resident, then reset in the middle of a miss
    fetch(32'h10, 2, -1, -1, 32'h00500093);
    fetch(32'h10, 0, -1, -1, 32'h0);
`ifdef ICACHE_STATS_EN
    check("stat_hit", hit_cnt, n_hit);
    check("stat_miss", miss_cnt, n_miss);
`endif
    if_req = 1'b1; if_addr = 32'h30010;
    @(posedge clk_in); #1;
    if_req = 1'b0;
    check("pre_rst_op", {30'd0, mc_op}, 32'd1);
    #3 rst_in = 1'b0;
    #1;
    check("arst_op", {30'd0, mc_op}, 32'd0);
    check("arst_rdy", {31'd0, if_rdy}, 32'd0);
    check("arst_addr", mc_addr, 32'd0);
    model_clear();
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    mc_rdy = 1'b1; mc_out = 32'hFFFFFFFF;
    @(posedge clk_in); #1;
    mc_rdy = 1'b0;
    check("late_rdy", {31'd0, if_rdy}, 32'd0);
    check("late_op", {30'd0, mc_op}, 32'd0);
    fetch(32'h10, 3, -1, -1, 32'h13579BDF);
    fetch(32'h10, 0, -1, -1, 32'h0);
`ifdef ICACHE_STATS_EN
    check("stat_hit2", hit_cnt, n_hit);
    check("stat_miss2", miss_cnt, n_miss);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
